// File: rtl/ctrl_pkg.sv
// Shared encodings for the pushbutton run-control slice.
package ctrl_pkg;

   localparam logic [1:0] MODE_HALT  = 2'b00;
   localparam logic [1:0] MODE_RUN   = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;
   localparam logic [1:0] MODE_FAULT = 2'b11;

   localparam int KEY_STEP = 0;
   localparam int KEY_RUN  = 1;
   localparam int KEY_CLR  = 2;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, stability counter, press pulse.
// Press pulse appears 2 + DEBOUNCE_CYCLES + 1 cycles after the key_n edge.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press
);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_stable   <= 1'b1;
         r_stable_d <= 1'b1;
         r_cnt      <= '0;
         r_press    <= 1'b0;
      end else begin
         r_sync1    <= i_key_n;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
         // Only a 1->0 transition of the accepted level is a press.
         r_press    <= r_stable_d & ~r_stable;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_level = r_stable;
   assign o_press = r_press;

endmodule

// File: rtl/key_step_ctrl.sv
// Pushbutton run control: HALT/RUN/STEP/FAULT FSM driving the core clock-enable.
// State and all outputs change one cycle after a debounced press event.
module key_step_ctrl
   import ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] i_key_n,
   input  logic       i_halt_req,
   output logic       o_cpu_en,
   output logic       o_step_pulse,
   output logic       o_clr_status,
   output logic [1:0] o_mode,
   output logic [2:0] o_key_pressed
);

   logic [2:0] w_level;
   logic [2:0] w_press;
   logic [1:0] w_next;

   logic [1:0] r_state;
   logic       r_cpu_en;
   logic       r_step_pulse;
   logic       r_clr_status;
   logic [2:0] r_key_pressed;

   for (genvar g = 0; g < 3; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .i_key_n (i_key_n[g]),
         .o_level (w_level[g]),
         .o_press (w_press[g])
      );
   end

   // FAULT is only reachable from RUN or STEP, so a lingering halt_req after clear is ignored.
   always_comb begin
      w_next = r_state;
      case (r_state)
         MODE_HALT: begin
            if (w_press[KEY_RUN])       w_next = MODE_RUN;
            else if (w_press[KEY_STEP]) w_next = MODE_STEP;
         end
         MODE_RUN: begin
            if (i_halt_req)             w_next = MODE_FAULT;
            else if (w_press[KEY_RUN])  w_next = MODE_HALT;
         end
         MODE_STEP:  w_next = i_halt_req ? MODE_FAULT : MODE_HALT;
         MODE_FAULT: begin
            if (w_press[KEY_CLR])       w_next = MODE_HALT;
         end
         default:    w_next = MODE_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= MODE_HALT;
         r_cpu_en      <= 1'b0;
         r_step_pulse  <= 1'b0;
         r_clr_status  <= 1'b0;
         r_key_pressed <= 3'b000;
      end else begin
         r_state       <= w_next;
         r_cpu_en      <= (w_next == MODE_RUN) || (w_next == MODE_STEP);
         r_step_pulse  <= (w_next == MODE_STEP);
         r_clr_status  <= w_press[KEY_CLR];
         r_key_pressed <= ~w_level;
      end
   end

   assign o_mode        = r_state;
   assign o_cpu_en      = r_cpu_en;
   assign o_step_pulse  = r_step_pulse;
   assign o_clr_status  = r_clr_status;
   assign o_key_pressed = r_key_pressed;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl with a short debounce window (4 cycles).
module tb_key_step_ctrl;

   logic       clk;
   logic       rst;
   logic [2:0] key_n;
   logic       halt_req;
   logic       cpu_en;
   logic       step_pulse;
   logic       clr_status;
   logic [1:0] mode;
   logic [2:0] key_pressed;

   int checks;
   int errors;
   int step_cnt;
   int en_cnt;
   int clr_cnt;

   key_step_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_key_n       (key_n),
      .i_halt_req    (halt_req),
      .o_cpu_en      (cpu_en),
      .o_step_pulse  (step_pulse),
      .o_clr_status  (clr_status),
      .o_mode        (mode),
      .o_key_pressed (key_pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n posedges, sampling 1 time unit after each and counting output pulses.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (step_pulse) step_cnt++;
         if (cpu_en)     en_cnt++;
         if (clr_status) clr_cnt++;
      end
   endtask

   task automatic drive_keys(input logic [2:0] v);
      @(negedge clk);
      key_n = v;
   endtask

   // Release all keys and let the release debounce fully settle.
   task automatic release_all();
      drive_keys(3'b111);
      tick(12);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      step_cnt = 0;
      en_cnt   = 0;
      clr_cnt  = 0;
      rst      = 1'b0;
      key_n    = 3'b000;
      halt_req = 1'b1;

      // Reset held with every key down and halt_req high.
      tick(5);
      chk("rst_mode", 32'(mode), 32'(2'b00));
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_pulses", 32'({step_pulse, clr_status}), 32'd0);
      chk("rst_keys", 32'(key_pressed), 32'(3'b000));

      // Release reset with keys still down: run beats step, clear only pulses.
      @(negedge clk);
      rst      = 1'b1;
      halt_req = 1'b0;
      step_cnt = 0;
      clr_cnt  = 0;
      tick(7);
      chk("boot_wait_mode", 32'(mode), 32'(2'b00));
      chk("boot_wait_keys", 32'(key_pressed), 32'(3'b111));
      tick(1);
      chk("boot_mode_run", 32'(mode), 32'(2'b01));
      chk("boot_cpu_en", 32'(cpu_en), 32'd1);
      chk("boot_clr", 32'(clr_status), 32'd1);
      tick(1);
      chk("boot_clr_off", 32'(clr_status), 32'd0);
      release_all();
      chk("boot_no_step", 32'(step_cnt), 32'd0);
      chk("boot_one_clr", 32'(clr_cnt), 32'd1);
      chk("boot_still_run", 32'(mode), 32'(2'b01));
      chk("boot_keys_up", 32'(key_pressed), 32'(3'b000));

      // Run key in RUN returns to HALT exactly 2 + 4 + 1 + 1 edges after the press.
      drive_keys(3'b101);
      tick(7);
      chk("halt_lat_before", 32'(mode), 32'(2'b01));
      tick(1);
      chk("halt_mode", 32'(mode), 32'(2'b00));
      chk("halt_cpu_en", 32'(cpu_en), 32'd0);
      tick(4);
      release_all();
      chk("halt_held_once", 32'(mode), 32'(2'b00));

      // Bouncy step key: 3 low, 2 high, 3 low never survives the window.
      step_cnt = 0;
      en_cnt   = 0;
      drive_keys(3'b110);
      tick(3);
      drive_keys(3'b111);
      tick(2);
      drive_keys(3'b110);
      tick(3);
      release_all();
      chk("bounce_mode", 32'(mode), 32'(2'b00));
      chk("bounce_no_step", 32'(step_cnt), 32'd0);

      // Clean step press held 10 cycles: one STEP cycle, then back to HALT.
      drive_keys(3'b110);
      tick(7);
      chk("step_before", 32'(mode), 32'(2'b00));
      tick(1);
      chk("step_mode", 32'(mode), 32'(2'b10));
      chk("step_pulse", 32'(step_pulse), 32'd1);
      chk("step_cpu_en", 32'(cpu_en), 32'd1);
      tick(1);
      chk("step_back_halt", 32'(mode), 32'(2'b00));
      chk("step_pulse_off", 32'(step_pulse), 32'd0);
      tick(1);
      release_all();
      chk("step_one_pulse", 32'(step_cnt), 32'd1);
      chk("step_one_en", 32'(en_cnt), 32'd1);

      // Run press: cpu_en stays high continuously.
      drive_keys(3'b101);
      tick(8);
      chk("run_mode", 32'(mode), 32'(2'b01));
      en_cnt = 0;
      tick(2);
      release_all();
      chk("run_en_steady", 32'(en_cnt), 32'd14);
      chk("run_mode_kept", 32'(mode), 32'(2'b01));

      // One-cycle halt_req in RUN latches FAULT.
      @(negedge clk);
      halt_req = 1'b1;
      tick(1);
      chk("fault_mode", 32'(mode), 32'(2'b11));
      chk("fault_cpu_en", 32'(cpu_en), 32'd0);
      @(negedge clk);
      halt_req = 1'b0;

      // Step and run together are ignored in FAULT.
      drive_keys(3'b100);
      tick(10);
      release_all();
      chk("fault_ignore", 32'(mode), 32'(2'b11));
      chk("fault_ignore_en", 32'(cpu_en), 32'd0);

      // Clear exits FAULT with a single clr_status pulse.
      clr_cnt = 0;
      drive_keys(3'b011);
      tick(7);
      chk("clr_before", 32'(clr_status), 32'd0);
      tick(1);
      chk("clr_mode", 32'(mode), 32'(2'b00));
      chk("clr_pulse", 32'(clr_status), 32'd1);
      tick(1);
      release_all();
      chk("clr_once", 32'(clr_cnt), 32'd1);

      // In RUN, run event and halt_req on the same edge: FAULT wins.
      drive_keys(3'b101);
      tick(8);
      chk("sim_pre_run", 32'(mode), 32'(2'b01));
      release_all();
      drive_keys(3'b101);
      tick(7);
      @(negedge clk);
      halt_req = 1'b1;
      tick(1);
      chk("sim_fault", 32'(mode), 32'(2'b11));
      @(negedge clk);
      halt_req = 1'b0;
      release_all();
      chk("sim_fault_kept", 32'(mode), 32'(2'b11));

      // Clear with halt_req still high: HALT, no re-entry to FAULT.
      @(negedge clk);
      halt_req = 1'b1;
      drive_keys(3'b011);
      tick(8);
      chk("clr_hreq_mode", 32'(mode), 32'(2'b00));
      tick(3);
      chk("clr_hreq_stay", 32'(mode), 32'(2'b00));
      @(negedge clk);
      halt_req = 1'b0;
      release_all();

      // Back to RUN, then reset while the step counter is mid-debounce.
      drive_keys(3'b101);
      tick(8);
      chk("mid_pre_run", 32'(mode), 32'(2'b01));
      release_all();
      drive_keys(3'b110);
      tick(4);
      @(negedge clk);
      rst   = 1'b0;
      key_n = 3'b111;
      tick(1);
      chk("mid_rst_mode", 32'(mode), 32'(2'b00));
      chk("mid_rst_en", 32'(cpu_en), 32'd0);
      @(negedge clk);
      rst      = 1'b1;
      step_cnt = 0;
      clr_cnt  = 0;
      en_cnt   = 0;
      tick(15);
      chk("mid_no_pulse", 32'({step_cnt[15:0], clr_cnt[7:0], en_cnt[7:0]}), 32'd0);
      chk("mid_mode", 32'(mode), 32'(2'b00));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/key_step_ctrl.md
Name: key_step_ctrl

Overview:
- Input-side companion to the 7-segment status display; turns board pushbuttons into processor run control.
- Synchronises and debounces three active-low pushbuttons and converts each press into a one-cycle pulse.
- Runs a HALT/RUN/STEP/FAULT state machine that drives the core clock-enable.
- Latches a fault when the core raises halt_req (exception or invalid PC) and holds it until the operator clears it.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronised key level must stay stable before it is accepted (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_n  in  3  raw pushbuttons, active-low, asynchronous to clk; [0]=step, [1]=run/halt toggle, [2]=clear
- halt_req  in  1  level from core, high while exception or PC_unvalid is asserted
- cpu_en  out  1  core clock-enable
- step_pulse  out  1  one-cycle pulse, high in the cycle the STEP state is entered
- clr_status  out  1  one-cycle pulse on each accepted clear press
- mode  out  2  current state: HALT=00, RUN=01, STEP=10, FAULT=11
- key_pressed  out  3  debounced key levels, 1 = held down

Behaviour:
- Reset, asynchronous on rst low:
  - synchroniser flops and stable levels = 1 (released); counters = 0.
  - state = HALT; cpu_en = 0; step_pulse = 0; clr_status = 0; mode = 00; key_pressed = 000.
- Synchroniser: two flops per key.
- Debounce, per key:
  - If the synchronised level equals the stable level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronised value and the counter clears.
  - Any mismatch that ends before then discards the count, so no level change is accepted.
- Press event: stable level changes 1->0. This produces a one-cycle internal pulse in the following cycle. Release events produce nothing.
- Latency: a clean press produces its event 2 (synchroniser) + DEBOUNCE_CYCLES + 1 cycles after the key_n edge, and the state moves one cycle later. A held key produces one event only.
- FSM transitions, registered, evaluated every cycle:
  - HALT: run event -> RUN; else step event -> STEP; else stay. Run has priority over step when both arrive together.
  - RUN: halt_req -> FAULT; else run event -> HALT; else stay. halt_req has priority over a simultaneous run event.
  - STEP: lasts exactly one cycle. Next state is FAULT if halt_req, else HALT. Events arriving during STEP are dropped.
  - FAULT: clear event -> HALT; run and step events are ignored. halt_req still high after the clear is not re-sampled from HALT; FAULT is entered only from RUN or STEP.
- Outputs:
  - cpu_en = 1 in RUN and STEP, 0 in HALT and FAULT. It is a registered decode of the next state, so cpu_en is high in the same cycle mode shows RUN or STEP.
  - step_pulse is high exactly during the STEP cycle.
  - clr_status pulses one cycle on every clear event in any state, including FAULT exit.
  - mode and key_pressed are registered.
- Reset mid-operation (mid-debounce or in RUN) returns everything to the reset values immediately. No pulse is generated on reset release.
- Simultaneous events on different keys are processed in the same cycle under the priorities above; a clear event in HALT/RUN/STEP only pulses clr_status.

Decomposition:
- Shared package, ctrl_pkg:
  - mode encodings HALT/RUN/STEP/FAULT as 2-bit localparams;
  - key index constants KEY_STEP=0, KEY_RUN=1, KEY_CLR=2.
- Sub-module key_debounce:
  - per-key synchroniser, counter, stable level and press pulse; parameters DEBOUNCE_CYCLES and CNT_W;
  - instantiated three times. The FSM stays in key_step_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: hold rst=0 with key_n=000 and halt_req=1 -> mode=00, cpu_en=0, no pulses. After release with keys still low -> no event until debounce completes, then a single HALT->STEP or HALT->RUN per priority (run wins) -> mode=01.
- Bounce: pulse key_n[0] low for 3 cycles, high 2, low 3 -> no event, mode stays 00. Then hold low for 10 cycles -> exactly one step_pulse, cpu_en high for 1 cycle, mode 00->10->00.
- Run/halt: press key[1] -> mode=01 and cpu_en=1 continuously. Press again -> mode=00, cpu_en=0 in the cycle after the event.
- Fault: in RUN, raise halt_req for 1 cycle -> mode=11, cpu_en=0. Press step and run -> no change. Press clear -> clr_status one cycle, mode=00.
- Simultaneous: in RUN, run event and halt_req in the same cycle -> mode=11, not 00.
- Mid-debounce reset: assert rst during counter=2 -> counter and state reset, no pulse after release.
